// File: rtl/sync_dual_port_ram.sv
// ---------------------------------------------------------------------------
// sync_dual_port_ram
//   True dual-port synchronous RAM with a self-clearing start-up sequence.
//   After reset the FSM spends exactly DEPTH cycles in INIT writing zero to
//   every word (busy = 1); port requests are ignored there.  In RUN, both
//   ports read or write independently every cycle with one cycle of read
//   latency.
//
//   Same-address rules in RUN:
//     * Both ports write the same address: port A's data is stored.
//     * One port writes and the other reads: the read returns the old word.
//       With SYNC_DPRAM_WR_FWD_EN defined, it returns the new word instead.
//     * Any write conflict on one address pulses collision on the next cycle.
//       Two reads of one address never count as a conflict.
//
//   Optional feature macro: SYNC_DPRAM_WR_FWD_EN (write-through forwarding).
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               synchronous, active-high; restarts the clear
//   a_cs / b_cs         port select
//   a_we / b_we         1 = write, 0 = read (when selected)
//   a_addr / b_addr     word address (ADDR_W bits)
//   a_wdata / b_wdata   write data (DATA_W bits)
//   a_rdata / b_rdata   registered read data; held until the next read
//   a_rvalid / b_rvalid one-cycle pulse marking new rdata
//   busy                high while the memory clear is running
//   collision           one-cycle pulse after a same-address write conflict
// ---------------------------------------------------------------------------
module sync_dual_port_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_cs,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_cs,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              busy,
  output logic              collision
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One extra bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              busy_q, busy_d;
  logic              collision_q, collision_d;

  logic              a_in_s, b_in_s, same_addr_s, a_wr_s, b_wr_s;
  logic              wr0_en_s, wr1_en_s;
  logic [ADDR_W-1:0] wr0_addr_s, wr1_addr_s;
  logic [DATA_W-1:0] wr0_data_s, wr1_data_s;

  // Address decode shared by the read, write and collision logic.
  always_comb begin
    a_in_s      = ({1'b0, a_addr} < DEPTH_L);
    b_in_s      = ({1'b0, b_addr} < DEPTH_L);
    same_addr_s = (a_addr == b_addr);
    a_wr_s      = a_cs & a_we & a_in_s;
    b_wr_s      = b_cs & b_we & b_in_s;
  end

  // Next-state, write-port steering and output computation.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    collision_d = 1'b0;
    wr0_en_s    = 1'b0;
    wr0_addr_s  = clr_cnt_q;
    wr0_data_s  = '0;
    wr1_en_s    = 1'b0;
    wr1_addr_s  = b_addr;
    wr1_data_s  = b_wdata;

    if (reset) begin
      state_d   = ST_INIT;
      clr_cnt_d = '0;
      a_rdata_d = '0;
      b_rdata_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Write port 0 is borrowed by the clear sequence.
          wr0_en_s = 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = ST_RUN;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          // Port A owns write port 0. Port B loses a same-address tie.
          wr0_en_s   = a_wr_s;
          wr0_addr_s = a_addr;
          wr0_data_s = a_wdata;
          wr1_en_s   = b_wr_s & ~(a_wr_s & same_addr_s);

          if (a_cs & ~a_we) begin
            a_rvalid_d = 1'b1;
            if (!a_in_s) begin
              a_rdata_d = '0;
`ifdef SYNC_DPRAM_WR_FWD_EN
            end else if (b_wr_s & same_addr_s) begin
              a_rdata_d = b_wdata;
`endif
            end else begin
              a_rdata_d = mem_q[a_addr];
            end
          end else begin
            a_rvalid_d = 1'b0;
          end

          if (b_cs & ~b_we) begin
            b_rvalid_d = 1'b1;
            if (!b_in_s) begin
              b_rdata_d = '0;
`ifdef SYNC_DPRAM_WR_FWD_EN
            end else if (a_wr_s & same_addr_s) begin
              b_rdata_d = a_wdata;
`endif
            end else begin
              b_rdata_d = mem_q[b_addr];
            end
          end else begin
            b_rvalid_d = 1'b0;
          end

          // At least one writer on a shared in-range address; read/read is fine.
          collision_d = a_cs & b_cs & same_addr_s & a_in_s & (a_we | b_we);
        end
        default: begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_INIT);
  end

  // Control and output registers (reset is folded into the _d logic).
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clr_cnt_q   <= clr_cnt_d;
    a_rdata_q   <= a_rdata_d;
    b_rdata_q   <= b_rdata_d;
    a_rvalid_q  <= a_rvalid_d;
    b_rvalid_q  <= b_rvalid_d;
    busy_q      <= busy_d;
    collision_q <= collision_d;
  end

  // Memory array: two write ports, never enabled for the same address together.
  always_ff @(posedge clk) begin
    if (wr0_en_s && !reset) begin
      mem_q[wr0_addr_s] <= wr0_data_s;
    end
    if (wr1_en_s && !reset) begin
      mem_q[wr1_addr_s] <= wr1_data_s;
    end
  end

  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign busy      = busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_sync_dual_port_ram
//   Drives two instances (DEPTH 1024 and DEPTH 1000, both ADDR_W = 10) with
//   the same stimulus. A behavioural memory model predicts every output on
//   every cycle, and directed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_sync_dual_port_ram;

`ifdef SYNC_DPRAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_cs = 1'b0, a_we = 1'b0, b_cs = 1'b0, b_we = 1'b0;
  logic [9:0] a_addr = 10'd0, b_addr = 10'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;

  logic [1:0][7:0] ard, brd;
  logic [1:0]      arv, brv, bsy, col;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_dual_port_ram #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024)) u0 (
    .clk(clk), .reset(reset),
    .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ard[0]), .a_rvalid(arv[0]),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(brd[0]), .b_rvalid(brv[0]),
    .busy(bsy[0]), .collision(col[0])
  );

  sync_dual_port_ram #(.ADDR_W(10), .DATA_W(8), .DEPTH(1000)) u1 (
    .clk(clk), .reset(reset),
    .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ard[1]), .a_rvalid(arv[1]),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(brd[1]), .b_rvalid(brv[1]),
    .busy(bsy[1]), .collision(col[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory contents as the ports should see them. A reset zeroes the whole
  // model at once: the clear finishes before any access is honoured.
  logic [7:0] m [2][1024];
  int         left [2];
  int         depth [2];
  logic [7:0] e_ard [2], e_brd [2];
  logic       e_arv [2], e_brv [2], e_bsy [2], e_col [2];
  bit         mv = 1'b0;

  initial begin
    depth[0] = 1024;
    depth[1] = 1000;
    left[0] = 0;
    left[1] = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          for (int j = 0; j < 1024; j++) m[i][j] = 8'd0;
          left[i] = depth[i];
          e_bsy[i] = 1'b1;
          e_ard[i] = 8'd0;
          e_brd[i] = 8'd0;
          e_arv[i] = 1'b0;
          e_brv[i] = 1'b0;
          e_col[i] = 1'b0;
        end else if (left[i] > 0) begin
          left[i]--;
          e_bsy[i] = (left[i] > 0);
          e_arv[i] = 1'b0;
          e_brv[i] = 1'b0;
          e_col[i] = 1'b0;
        end else begin
          e_bsy[i] = 1'b0;
          e_arv[i] = a_cs && !a_we;
          e_brv[i] = b_cs && !b_we;
          if (a_cs && !a_we) begin
            if (int'(a_addr) >= depth[i]) e_ard[i] = 8'd0;
            else if (FWD && b_cs && b_we && b_addr == a_addr) e_ard[i] = b_wdata;
            else e_ard[i] = m[i][a_addr];
          end
          if (b_cs && !b_we) begin
            if (int'(b_addr) >= depth[i]) e_brd[i] = 8'd0;
            else if (FWD && a_cs && a_we && a_addr == b_addr) e_brd[i] = a_wdata;
            else e_brd[i] = m[i][b_addr];
          end
          e_col[i] = a_cs && b_cs && (a_we || b_we) && (a_addr == b_addr)
                     && (int'(a_addr) < depth[i]);
          // B first, then A, so A wins a same-address tie.
          if (b_cs && b_we && int'(b_addr) < depth[i]) m[i][b_addr] = b_wdata;
          if (a_cs && a_we && int'(a_addr) < depth[i]) m[i][a_addr] = a_wdata;
        end
      end
      if (reset) mv = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("u%0d.busy", i), 32'(bsy[i]), 32'(e_bsy[i]));
          check($sformatf("u%0d.a_rvalid", i), 32'(arv[i]), 32'(e_arv[i]));
          check($sformatf("u%0d.b_rvalid", i), 32'(brv[i]), 32'(e_brv[i]));
          check($sformatf("u%0d.a_rdata", i), 32'(ard[i]), 32'(e_ard[i]));
          check($sformatf("u%0d.b_rdata", i), 32'(brd[i]), 32'(e_brd[i]));
          check($sformatf("u%0d.collision", i), 32'(col[i]), 32'(e_col[i]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic acs, input logic awe, input logic [9:0] aad,
                        input logic [7:0] awd, input logic bcs, input logic bwe,
                        input logic [9:0] bad, input logic [7:0] bwd);
    @(negedge clk);
    a_cs = acs; a_we = awe; a_addr = aad; a_wdata = awd;
    b_cs = bcs; b_we = bwe; b_addr = bad; b_wdata = bwd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 10'd0, 8'd0);
  endtask

  task automatic rand_in();
    logic [9:0] aa, ba;
    aa = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
    ba = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
    set_in(1'($urandom), 1'($urandom), aa, 8'($urandom),
           1'($urandom), 1'($urandom), ba, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts busy cycles of both instances while random requests are applied.
  task automatic wait_clear(input string tag);
    int c0, c1, rv;
    c0 = 0; c1 = 0; rv = 0;
    for (int n = 0; n < 3000; n++) begin
      if (bsy[0]) c0++;
      if (bsy[1]) c1++;
      if (bsy[0] && (arv[0] || brv[0])) rv++;
      if (!bsy[0] && !bsy[1]) break;
      rand_in();
    end
    a_cs = 1'b0;
    b_cs = 1'b0;
    check({tag, ".busy_cycles_u0"}, 32'(c0), 32'd1024);
    check({tag, ".busy_cycles_u1"}, 32'(c1), 32'd1000);
    check({tag, ".rvalid_in_init"}, 32'(rv), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();
    check("reset.busy", 32'(bsy[0]), 32'd1);
    check("reset.a_rdata", 32'(ard[0]), 32'd0);
    check("reset.collision", 32'(col[0]), 32'd0);
    wait_clear("init1");

    // Freshly cleared words read as zero.
    set_in(1'b1, 1'b0, 10'd0, 8'd0, 1'b1, 1'b0, 10'd1023, 8'd0);
    idle();
    check("clr.a_rdata0", 32'(ard[0]), 32'd0);
    check("clr.a_rvalid0", 32'(arv[0]), 32'd1);
    check("clr.b_rdata1023", 32'(brd[0]), 32'd0);
    check("clr.b_rvalid1023", 32'(brv[0]), 32'd1);

    // A writes k*2 to k while B reads back the previous word.
    for (int k = 0; k < 1024; k++) begin
      set_in(1'b1, 1'b1, 10'(k), 8'(k * 2), (k > 0), 1'b0, 10'(k - 1), 8'd0);
    end
    set_in(1'b0, 1'b0, 10'd0, 8'd0, 1'b1, 1'b0, 10'd1023, 8'd0);
    idle();
    check("fill.b_rdata1023", 32'(brd[0]), 32'hFE);
    check("fill.b_rvalid", 32'(brv[0]), 32'd1);

    // Write/write collision: port A wins.
    set_in(1'b1, 1'b1, 10'd5, 8'hAA, 1'b1, 1'b1, 10'd5, 8'h55);
    idle();
    check("ww.collision", 32'(col[0]), 32'd1);
    check("ww.model_collision", 32'(e_col[0]), 32'd1);
    set_in(1'b1, 1'b0, 10'd5, 8'd0, 1'b0, 1'b0, 10'd0, 8'd0);
    idle();
    check("ww.a_rdata5", 32'(ard[0]), 32'hAA);
    check("ww.no_collision", 32'(col[0]), 32'd0);

    // Write/read collision: forwarded or old data.
    set_in(1'b1, 1'b1, 10'd7, 8'h11, 1'b0, 1'b0, 10'd0, 8'd0);
    set_in(1'b1, 1'b1, 10'd7, 8'h22, 1'b1, 1'b0, 10'd7, 8'd0);
    idle();
    check("wr.b_rdata7", 32'(brd[0]), FWD ? 32'h22 : 32'h11);
    check("wr.model_b_rdata7", 32'(e_brd[0]), FWD ? 32'h22 : 32'h11);
    check("wr.collision", 32'(col[0]), 32'd1);

    // Read/read on one address is not a collision.
    set_in(1'b1, 1'b0, 10'd7, 8'd0, 1'b1, 1'b0, 10'd7, 8'd0);
    idle();
    check("rr.collision", 32'(col[0]), 32'd0);
    check("rr.a_rdata7", 32'(ard[0]), 32'h22);

    // Out-of-range access on the DEPTH=1000 instance.
    set_in(1'b1, 1'b1, 10'd1010, 8'hFF, 1'b0, 1'b0, 10'd0, 8'd0);
    set_in(1'b1, 1'b0, 10'd1010, 8'd0, 1'b0, 1'b0, 10'd0, 8'd0);
    idle();
    check("oor.u1_a_rdata", 32'(ard[1]), 32'd0);
    check("oor.u1_a_rvalid", 32'(arv[1]), 32'd1);
    check("oor.u0_a_rdata", 32'(ard[0]), 32'hFF);
    set_in(1'b1, 1'b1, 10'd999, 8'h3C, 1'b0, 1'b0, 10'd0, 8'd0);
    set_in(1'b0, 1'b0, 10'd0, 8'd0, 1'b1, 1'b0, 10'd999, 8'd0);
    idle();
    check("edge.u1_b_rdata999", 32'(brd[1]), 32'h3C);

    // Randomized traffic, biased toward a small address window for conflicts.
    repeat (3000) rand_in();
    idle();

    // Reset mid-INIT, then again after RUN traffic: the clear restarts fully.
    do_reset();
    repeat (500) rand_in();
    do_reset();
    wait_clear("init2");
    for (int k = 0; k < 1024; k++) begin
      set_in(1'b1, 1'b0, 10'(k), 8'd0, 1'b1, 1'b0, 10'(1023 - k), 8'd0);
    end
    set_in(1'b1, 1'b0, 10'd5, 8'd0, 1'b1, 1'b0, 10'd999, 8'd0);
    idle();
    check("rst2.a_rdata5", 32'(ard[0]), 32'd0);
    check("rst2.b_rdata999", 32'(brd[0]), 32'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the sequence ends far earlier than this bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sync_dual_port_ram.md
SYNC_DUAL_PORT_RAM -- requirements
Module: sync_dual_port_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, address width of each port.
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; legal range 2..2^ADDR_W.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_cs / b_cs  input  1  port A / B select.
REQ-007 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read (when selected).
REQ-008 SHALL have ports a_addr / b_addr  input  ADDR_W  word address.
REQ-009 SHALL have ports a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports a_rdata / b_rdata  output  DATA_W  registered read data.
REQ-011 SHALL have ports a_rvalid / b_rvalid  output  1  one-cycle pulse marking new rdata.
REQ-012 SHALL have port busy  output  1  high while memory clear is in progress.
REQ-013 SHALL have port collision  output  1  one-cycle pulse on same-address conflict.

Function
REQ-014 SHALL implement FSM states INIT and RUN; INIT writes 0 to address clr_cnt each cycle, clr_cnt counting 0..DEPTH-1.
REQ-015 SHALL transition INIT->RUN on the cycle clr_cnt = DEPTH-1 is written; INIT thus lasts exactly DEPTH cycles after reset deasserts.
REQ-016 SHALL hold busy = 1 in INIT, 0 in RUN; all port requests in INIT ignored (no write, no rvalid).
REQ-017 SHALL, in RUN, on x_cs=1 & x_we=1, write x_wdata to mem[x_addr] at that clock edge.
REQ-018 SHALL, in RUN, on x_cs=1 & x_we=0, present mem[x_addr] on x_rdata and pulse x_rvalid = 1 on the following cycle (latency 1).
REQ-019 SHALL hold x_rdata unchanged when no read completes; x_rvalid = 0 otherwise.
REQ-020 SHALL ignore writes to x_addr >= DEPTH; reads of x_addr >= DEPTH SHALL return 0 with x_rvalid pulsed.
REQ-021 SHALL, on both ports writing the same in-range address in one cycle, store a_wdata (port A wins) and pulse collision next cycle.
REQ-022 SHALL, on one port writing and the other reading the same in-range address in one cycle, pulse collision next cycle; read data per REQ-026/027.
REQ-023 SHALL NOT assert collision for two reads of the same address, nor for any access during INIT.
REQ-024 SHALL allow both ports to operate fully independently every cycle on differing addresses.

Reset
REQ-025 SHALL, while reset = 1 at a clock edge: state = INIT, clr_cnt = 0, a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, collision = 0, busy = 1; reset asserted mid-INIT or mid-RUN restarts the clear from address 0.

Configuration
REQ-026 SHALL, with macro SYNC_DPRAM_WR_FWD_EN defined, return the newly written data to a port reading an address written by the other port in the same cycle (write-through forwarding).
REQ-027 SHALL, without SYNC_DPRAM_WR_FWD_EN, return the old (pre-write) contents in that case (read-first); all other behaviour identical.

Verification
REQ-028 SHALL cover: reset 1 cycle, DEPTH=1024 -> busy high exactly 1024 cycles; afterwards read of addr 0 and 1023 returns 0; reads during busy give no rvalid.
REQ-029 SHALL cover: A writes k*2 (mod 256) to addr k for k=0..1023, B reads addr k -> b_rdata = k*2 mod 256 one cycle after each read, b_rvalid pulsed each.
REQ-030 SHALL cover: A writes 8'hAA and B writes 8'h55 to addr 5 same cycle -> collision pulse next cycle; subsequent read of addr 5 = 8'hAA.
REQ-031 SHALL cover: addr 7 holds 8'h11; A writes 8'h22 and B reads addr 7 same cycle -> b_rdata = 8'h22 with SYNC_DPRAM_WR_FWD_EN, 8'h11 without; collision pulsed.
REQ-032 SHALL cover: ADDR_W=10, DEPTH=1000; write 8'hFF to addr 1010 then read it -> rdata = 0; addr 999 read/write normally.
REQ-033 SHALL cover: reset asserted at cycle 500 of INIT and again during RUN after writes -> busy high for full DEPTH cycles again, all previously written words read back 0.
